// File: rtl/sram_port_client.sv
// sram_port_client
//   Request front-end for one port of the SRAM mux. Core commands are queued
//   in a small FIFO; the head entry is issued to the mux as a single-cycle
//   request, its acceptance (busy rising) and completion (busy falling) are
//   tracked, and a response is returned to the core. A request that is never
//   picked up within ACCEPT_TIMEOUT cycles is re-issued from the same head.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      core command handshake (ready = FIFO not full)
//   cmd_wr/addr/wdata        command payload
//   rsp_valid                one-cycle completion pulse
//   rsp_wr, rsp_rdata        completed command type / read data (held)
//   level                    FIFO occupancy
//   retry_pulse              one-cycle pulse on each accept timeout
//   hold_off                 higher-priority port requesting; blocks issue
//   sram_req/wr/rd/addr/wdata  mux port request (only non-zero in ISSUE)
//   sram_rdata, sram_valid, sram_busy  mux/controller return signals
module sram_port_client #(
  parameter int DEPTH          = 4,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int ACCEPT_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_wr,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  output logic                     rsp_wr,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     retry_pulse,
  input  logic                     hold_off,
  output logic                     sram_req,
  output logic                     sram_wr,
  output logic                     sram_rd,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  input  logic [DATA_W-1:0]        sram_rdata,
  input  logic                     sram_valid,
  input  logic                     sram_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(ACCEPT_TIMEOUT + 1);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACC, WAIT_DONE, DONE
  } state_t;

  // ---------------------------------------------------------------- FIFO
  cmd_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              full, push, pop;
  cmd_t              head, cmd_in;

  state_t            state, state_nxt;

  assign full      = (count == LVL_W'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  // The head stays in place across retries; it only leaves on completion.
  assign pop       = (state == DONE);
  assign head      = mem[rd_ptr];
  assign level     = count;
  assign cmd_in    = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_timeout;
  logic             got_data;

  always_comb begin
    state_nxt   = state;
    acc_timeout = 1'b0;
    case (state)
      IDLE:
        if (count != '0 && !sram_busy && !hold_off) state_nxt = ISSUE;
      ISSUE:
        state_nxt = WAIT_ACC;
      WAIT_ACC:
        if (sram_busy) begin
          state_nxt = WAIT_DONE;
        end else if (acc_cnt == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
          // This cycle's increment would reach the timeout: give up and
          // let IDLE re-issue the same head entry.
          state_nxt   = IDLE;
          acc_timeout = 1'b1;
        end
      WAIT_DONE:
        if (!sram_busy) state_nxt = DONE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc_cnt     <= '0;
      got_data    <= 1'b0;
      retry_pulse <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_nxt;
      retry_pulse <= acc_timeout;
      rsp_valid   <= 1'b0;
      case (state)
        ISSUE: begin
          acc_cnt  <= '0;
          got_data <= 1'b0;
        end
        WAIT_ACC:
          if (!sram_busy) acc_cnt <= acc_cnt + 1'b1;
        WAIT_DONE: begin
          // First read beat of the operation wins; if none arrives the read
          // still completes and rsp_rdata keeps its previous value.
          if (sram_valid && !head.wr && !got_data) begin
            rsp_rdata <= sram_rdata;
            got_data  <= 1'b1;
          end
          // Registered so the pulse lines up with the DONE cycle.
          if (!sram_busy) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= head.wr;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- mux port
  // Decoded from the state register, so every field is zero outside ISSUE.
  logic issuing;
  assign issuing    = (state == ISSUE);
  assign sram_req   = issuing;
  assign sram_wr    = issuing &&  head.wr;
  assign sram_rd    = issuing && !head.wr;
  assign sram_addr  = issuing ? head.addr  : '0;
  assign sram_wdata = issuing ? head.wdata : '0;

endmodule
